// File: rtl/debounce_2ch_if.sv
// Switch-side signals of the two-channel debouncer: raw inputs, debounced levels, rise ticks.
interface debounce_2ch_if;
    logic sw_a;
    logic sw_b;
    logic db_a;
    logic db_b;
    logic tick_a;
    logic tick_b;

    modport master (output sw_a, sw_b, input db_a, db_b, tick_a, tick_b);
    modport slave  (input sw_a, sw_b, output db_a, db_b, tick_a, tick_b);
endinterface

// File: rtl/debounce_2ch.sv
// Two independent switch debouncers sharing one 2^N-cycle tick; a level must survive 3 ticks.
// Define DEBOUNCE_2CH_TICK_EN to generate the one-cycle rise pulses on tick_a/tick_b.
module debounce_2ch #(
    parameter int unsigned N = 19
) (
    input  logic          clk,
    input  logic          reset,
    debounce_2ch_if.slave pins
);

    typedef enum logic [2:0] {
        StZero,
        StW11,
        StW12,
        StW13,
        StOne,
        StW01,
        StW02,
        StW03
    } state_e;

    logic [1:0]   sync1_q;
    logic [1:0]   sync2_q;
    logic [N-1:0] cnt_q;
    logic         m_tick;
    state_e       state_q [2];
    state_e       state_d [2];
    logic [1:0]   db;
`ifdef DEBOUNCE_2CH_TICK_EN
    logic [1:0]   tick;
`endif

    // Counter free-runs; input activity never restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            state_q[0] <= StZero;
            state_q[1] <= StZero;
        end else begin
            sync1_q    <= {pins.sw_b, pins.sw_a};
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_q + 1'b1;
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    assign m_tick = (cnt_q == '0);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            db[i]      = 1'b0;
`ifdef DEBOUNCE_2CH_TICK_EN
            tick[i]    = 1'b0;
`endif
            case (state_q[i])
                StZero: begin
                    if (sync2_q[i]) state_d[i] = StW11;
                end
                StW11: begin
                    if (!sync2_q[i])  state_d[i] = StZero;
                    else if (m_tick)  state_d[i] = StW12;
                end
                StW12: begin
                    if (!sync2_q[i])  state_d[i] = StZero;
                    else if (m_tick)  state_d[i] = StW13;
                end
                StW13: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StZero;
                    end else if (m_tick) begin
                        state_d[i] = StOne;
`ifdef DEBOUNCE_2CH_TICK_EN
                        tick[i]    = 1'b1;
`endif
                    end
                end
                StOne: begin
                    db[i] = 1'b1;
                    if (!sync2_q[i]) state_d[i] = StW01;
                end
                StW01: begin
                    db[i] = 1'b1;
                    if (sync2_q[i])   state_d[i] = StOne;
                    else if (m_tick)  state_d[i] = StW02;
                end
                StW02: begin
                    db[i] = 1'b1;
                    if (sync2_q[i])   state_d[i] = StOne;
                    else if (m_tick)  state_d[i] = StW03;
                end
                StW03: begin
                    db[i] = 1'b1;
                    if (sync2_q[i])   state_d[i] = StOne;
                    else if (m_tick)  state_d[i] = StZero;
                end
                default: state_d[i] = StZero;
            endcase
        end
    end

    assign pins.db_a = db[0];
    assign pins.db_b = db[1];
`ifdef DEBOUNCE_2CH_TICK_EN
    assign pins.tick_a = tick[0];
    assign pins.tick_b = tick[1];
`else
    assign pins.tick_a = 1'b0;
    assign pins.tick_b = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_2ch.sv
// Directed bench for debounce_2ch with N=3; stimulus is launched at counter phase 5 so that
// a held edge lands on db exactly 20 cycles later (tick one cycle earlier when enabled).
module tb_debounce_2ch;

    localparam int unsigned N = 3;
    localparam int Settle = 20;
    localparam int AfterRst = 25;
`ifdef DEBOUNCE_2CH_TICK_EN
    localparam int TickN     = 1;
    localparam int TickAt    = Settle - 1;
    localparam int TickAtRst = AfterRst - 1;
`else
    localparam int TickN     = 0;
    localparam int TickAt    = -1;
    localparam int TickAtRst = -1;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] cnt_m;
    int           n_total = 0;
    int           n_bad   = 0;
    int           a_chg, b_chg, ta_n, ta_at, tb_n, tb_at;

    debounce_2ch_if dbif ();

    debounce_2ch #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .pins  (dbif.slave)
    );

    initial begin
        clk = 1'b0;
        #5;
        forever #10 clk = ~clk;
    end

    // Phase reference used only to launch stimulus at a known counter value.
    always @(posedge clk or posedge reset) begin
        if (reset) cnt_m <= '0;
        else       cnt_m <= cnt_m + 1'b1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align();
        do begin
            step();
        end while (cnt_m != 3'd5);
    endtask

    // Records the first cycle each db changes and the tick activity over n cycles.
    task automatic window(input int n);
        logic a0, b0;
        a0 = dbif.db_a;
        b0 = dbif.db_b;
        a_chg = -1; b_chg = -1;
        ta_n = 0; ta_at = -1; tb_n = 0; tb_at = -1;
        for (int j = 1; j <= n; j++) begin
            step();
            if (a_chg < 0 && dbif.db_a != a0) a_chg = j;
            if (b_chg < 0 && dbif.db_b != b0) b_chg = j;
            if (dbif.tick_a) begin
                ta_n++;
                if (ta_at < 0) ta_at = j;
            end
            if (dbif.tick_b) begin
                tb_n++;
                if (tb_at < 0) tb_at = j;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        dbif.sw_a = 1'b0;
        dbif.sw_b = 1'b0;

        // Reset held 30 ns
        #16;
        check("rst_db_a", dbif.db_a, 0);
        check("rst_db_b", dbif.db_b, 0);
        check("rst_tick_a", dbif.tick_a, 0);
        check("rst_tick_b", dbif.tick_b, 0);
        #14;
        reset = 1'b0;
        #1;
        check("rel_cnt", int'(dut.cnt_q), 0);
        check("rel_db_a", dbif.db_a, 0);
        check("rel_db_b", dbif.db_b, 0);

        // Single-channel rise
        align();
        dbif.sw_a = 1'b1;
        window(40);
        check("rise_a_cyc", a_chg, Settle);
        check("rise_a_tick_n", ta_n, TickN);
        check("rise_a_tick_at", ta_at, TickAt);
        check("rise_a_db_b", b_chg, -1);
        check("rise_a_tick_b", tb_n, 0);

        // Fall, rise again, then a short glitch while in ONE
        align();
        dbif.sw_a = 1'b0;
        window(40);
        check("fall_a_cyc", a_chg, Settle);
        check("fall_a_tick_n", ta_n, 0);
        align();
        dbif.sw_a = 1'b1;
        window(40);
        check("rerise_a_cyc", a_chg, Settle);
        align();
        dbif.sw_a = 1'b0;
        repeat (3) step();
        dbif.sw_a = 1'b1;
        window(40);
        check("glitch_a_chg", a_chg, -1);
        check("glitch_a_db", dbif.db_a, 1);
        check("glitch_a_tick", ta_n, 0);
        align();
        dbif.sw_a = 1'b0;
        window(40);
        check("fall2_a_cyc", a_chg, Settle);

        // Both channels together
        align();
        dbif.sw_a = 1'b1;
        dbif.sw_b = 1'b1;
        window(40);
        check("both_rise_a", a_chg, Settle);
        check("both_rise_b", b_chg, Settle);
        check("both_tick_a_at", ta_at, TickAt);
        check("both_tick_b_at", tb_at, TickAt);
        check("both_tick_b_n", tb_n, TickN);
        align();
        dbif.sw_a = 1'b0;
        dbif.sw_b = 1'b0;
        window(40);
        check("both_fall_a", a_chg, Settle);
        check("both_fall_b", b_chg, Settle);

        // Bounce: 5-cycle pulse aborts in a wait state
        align();
        dbif.sw_a = 1'b1;
        repeat (5) step();
        dbif.sw_a = 1'b0;
        window(40);
        check("bounce_a_chg", a_chg, -1);
        check("bounce_a_tick", ta_n, 0);
        check("bounce_a_db", dbif.db_a, 0);

        // Reset while in W1_2 discards the progress made so far
        align();
        dbif.sw_a = 1'b1;
        repeat (6) step();
        reset = 1'b1;
        #1;
        check("midrst_cnt", int'(dut.cnt_q), 0);
        check("midrst_db_a", dbif.db_a, 0);
        check("midrst_tick_a", dbif.tick_a, 0);
        step();
        reset = 1'b0;
        window(40);
        check("midrst_rise_cyc", a_chg, AfterRst);
        check("midrst_tick_at", ta_at, TickAtRst);
        check("midrst_tick_n", ta_n, TickN);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
